// File: rtl/sdram_sched.sv
// SDRAM sequencing controller: power-up init, then one-at-a-time arbitration
// of periodic refresh, write bursts and read bursts for the command generator.
module sdram_sched #(
  parameter int unsigned T_POWERUP   = 20000,
  parameter int unsigned T_RP        = 2,
  parameter int unsigned T_RFC       = 7,
  parameter int unsigned T_MRD       = 3,
  parameter int unsigned T_RCD       = 2,
  parameter int unsigned CAS_LAT     = 3,
  parameter int unsigned T_WR        = 2,
  parameter int unsigned INIT_AR_NUM = 8,
  parameter int unsigned REF_PERIOD  = 780
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdram_wr_req,
  input  logic       sdram_rd_req,
  input  logic [9:0] sdram_wr_burst,
  input  logic [9:0] sdram_rd_burst,
  output logic       sdram_wr_ack,
  output logic       sdram_rd_ack,
  output logic       sdram_init_done,
  output logic [4:0] init_state,
  output logic [3:0] work_state,
  output logic [9:0] cnt_clk,
  output logic       sdram_rd_wr
);

  localparam logic [4:0] I_NOP  = 5'd0;
  localparam logic [4:0] I_PRE  = 5'd1;
  localparam logic [4:0] I_TRP  = 5'd2;
  localparam logic [4:0] I_AR   = 5'd3;
  localparam logic [4:0] I_TRF  = 5'd4;
  localparam logic [4:0] I_MRS  = 5'd5;
  localparam logic [4:0] I_TRSC = 5'd6;
  localparam logic [4:0] I_DONE = 5'd7;

  localparam logic [3:0] W_IDLE   = 4'd0;
  localparam logic [3:0] W_ACTIVE = 4'd1;
  localparam logic [3:0] W_TRCD   = 4'd2;
  localparam logic [3:0] W_READ   = 4'd3;
  localparam logic [3:0] W_CL     = 4'd4;
  localparam logic [3:0] W_RD     = 4'd5;
  localparam logic [3:0] W_WRITE  = 4'd6;
  localparam logic [3:0] W_WD     = 4'd7;
  localparam logic [3:0] W_TWR    = 4'd8;
  localparam logic [3:0] W_PRE    = 4'd9;
  localparam logic [3:0] W_TRP    = 4'd10;
  localparam logic [3:0] W_AR     = 4'd11;
  localparam logic [3:0] W_TRFC   = 4'd12;

  localparam int unsigned PW_W = (T_POWERUP > 1)   ? $clog2(T_POWERUP + 1)   : 1;
  localparam int unsigned RF_W = (REF_PERIOD > 1)  ? $clog2(REF_PERIOD + 1)  : 1;
  localparam int unsigned AR_W = (INIT_AR_NUM > 1) ? $clog2(INIT_AR_NUM + 1) : 1;

  // Power-up wait is longer than cnt_clk can count, so it has its own counter.
  logic [PW_W-1:0] pwr_cnt;
  logic [AR_W-1:0] ar_cnt;
  logic [RF_W-1:0] ref_cnt;
  logic            ref_pending;
  logic [9:0]      burst;
  logic [4:0]      init_next;
  logic [3:0]      work_next;
  logic            load;
  logic            load_rd;
  logic [9:0]      burst_sel;
  logic            ref_wrap;

  assign sdram_init_done = (init_state == I_DONE);
  assign sdram_wr_ack    = (work_state == W_WRITE) || (work_state == W_WD);
  assign ref_wrap        = sdram_init_done && (ref_cnt == RF_W'(REF_PERIOD - 1));
  assign burst_sel       = load_rd ? sdram_rd_burst : sdram_wr_burst;

  always_comb begin
    init_next = init_state;
    case (init_state)
      I_NOP:  if (pwr_cnt == PW_W'(T_POWERUP - 1)) init_next = I_PRE;
      I_PRE:  init_next = I_TRP;
      I_TRP:  if (cnt_clk == 10'(T_RP - 1)) init_next = I_AR;
      I_AR:   init_next = I_TRF;
      I_TRF:  if (cnt_clk == 10'(T_RFC - 1))
                init_next = (ar_cnt == AR_W'(INIT_AR_NUM)) ? I_MRS : I_AR;
      I_MRS:  init_next = I_TRSC;
      I_TRSC: if (cnt_clk == 10'(T_MRD - 1)) init_next = I_DONE;
      I_DONE: init_next = I_DONE;
      default: init_next = I_NOP;
    endcase
  end

  always_comb begin
    work_next = work_state;
    load      = 1'b0;
    load_rd   = 1'b0;
    if (init_state == I_DONE) begin
      case (work_state)
        W_IDLE: begin
          if (ref_pending) begin
            work_next = W_AR;
          end else if (sdram_wr_req) begin
            work_next = W_ACTIVE;
            load      = 1'b1;
          end else if (sdram_rd_req) begin
            work_next = W_ACTIVE;
            load      = 1'b1;
            load_rd   = 1'b1;
          end
        end
        W_ACTIVE: work_next = W_TRCD;
        W_TRCD:   if (cnt_clk == 10'(T_RCD - 1)) work_next = sdram_rd_wr ? W_READ : W_WRITE;
        // Single-beat writes have no W_WD cycles at all.
        W_WRITE:  work_next = (burst == 10'd1) ? W_TWR : W_WD;
        W_WD:     if (cnt_clk == burst - 10'd2) work_next = W_TWR;
        W_TWR:    if (cnt_clk == 10'(T_WR - 1)) work_next = W_PRE;
        W_READ:   work_next = (CAS_LAT > 1) ? W_CL : W_RD;
        W_CL:     if (cnt_clk == 10'(CAS_LAT - 2)) work_next = W_RD;
        W_RD:     if (cnt_clk == burst - 10'd1) work_next = W_PRE;
        W_PRE:    work_next = W_TRP;
        W_TRP:    if (cnt_clk == 10'(T_RP - 1)) work_next = W_IDLE;
        W_AR:     work_next = W_TRFC;
        W_TRFC:   if (cnt_clk == 10'(T_RFC - 1)) work_next = W_IDLE;
        default:  work_next = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_state   <= I_NOP;
      work_state   <= W_IDLE;
      cnt_clk      <= '0;
      sdram_rd_wr  <= 1'b1;
      sdram_rd_ack <= 1'b0;
      pwr_cnt      <= '0;
      ar_cnt       <= '0;
      ref_cnt      <= '0;
      ref_pending  <= 1'b0;
      burst        <= 10'd1;
    end else begin
      init_state <= init_next;
      work_state <= work_next;

      if ((init_next != init_state) || (work_next != work_state)) cnt_clk <= '0;
      else if (cnt_clk != '1) cnt_clk <= cnt_clk + 10'd1;

      if (init_state == I_NOP) pwr_cnt <= pwr_cnt + 1'b1;
      if (init_state == I_AR)  ar_cnt  <= ar_cnt + 1'b1;

      if (load) begin
        sdram_rd_wr <= load_rd;
        burst       <= (burst_sel == '0) ? 10'd1 : burst_sel;
      end

      // Registered to line up with the command-register stage downstream.
      sdram_rd_ack <= (work_state == W_RD);

      if (sdram_init_done) ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;

      // A wrap coinciding with W_AR entry is a fresh request and must survive.
      if (ref_wrap) ref_pending <= 1'b1;
      else if ((work_state == W_IDLE) && (work_next == W_AR)) ref_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdram_sched.sv
// Directed self-checking bench for sdram_sched with shortened power-up and
// refresh period; expected timelines are hand-derived cycle counts.
module tb_sdram_sched;

  localparam logic [4:0] I_NOP = 5'd0, I_PRE = 5'd1, I_AR = 5'd3, I_DONE = 5'd7;
  localparam logic [3:0] W_IDLE = 4'd0, W_ACTIVE = 4'd1, W_TRCD = 4'd2, W_READ = 4'd3,
                         W_CL = 4'd4, W_RD = 4'd5, W_WRITE = 4'd6, W_WD = 4'd7,
                         W_TWR = 4'd8, W_PRE = 4'd9, W_TRP = 4'd10, W_AR = 4'd11,
                         W_TRFC = 4'd12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sdram_wr_req = 1'b0;
  logic       sdram_rd_req = 1'b0;
  logic [9:0] sdram_wr_burst = 10'd0;
  logic [9:0] sdram_rd_burst = 10'd0;
  logic       sdram_wr_ack;
  logic       sdram_rd_ack;
  logic       sdram_init_done;
  logic [4:0] init_state;
  logic [3:0] work_state;
  logic [9:0] cnt_clk;
  logic       sdram_rd_wr;

  int compared = 0;
  int mismatched = 0;
  logic [6:0] exp_q[$];

  sdram_sched #(.T_POWERUP(100), .REF_PERIOD(50)) dut (
    .clk(clk), .rst_n(rst_n),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sdram_wr_burst(sdram_wr_burst), .sdram_rd_burst(sdram_rd_burst),
    .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
    .sdram_init_done(sdram_init_done), .init_state(init_state),
    .work_state(work_state), .cnt_clk(cnt_clk), .sdram_rd_wr(sdram_rd_wr)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic add(input logic [3:0] st, input int n, input logic wa, input logic ra,
                     input logic rdwr);
    repeat (n) exp_q.push_back({st, wa, ra, rdwr});
  endtask

  // Each entry is {work_state, wr_ack, rd_ack, rd_wr} for one cycle; the
  // requester drops its request on its first ack.
  task automatic run_seq(input string tag, input bit mut);
    for (int i = 0; i < exp_q.size(); i++) begin
      cyc();
      if (i == 0 && mut) begin
        sdram_wr_burst = 10'd1;
        sdram_rd_burst = 10'd2;
      end
      chk($sformatf("%s[%0d]", tag, i),
          {25'd0, work_state, sdram_wr_ack, sdram_rd_ack, sdram_rd_wr}, {25'd0, exp_q[i]});
      if (sdram_wr_ack) sdram_wr_req = 1'b0;
      if (sdram_rd_ack) sdram_rd_req = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic run_init(input string tag);
    int n = 0;
    int pre_at = -1;
    int ars = 0;
    logic [9:0] c99 = '0;
    bit early = 1'b0;
    bit ack = 1'b0;
    while (init_state != I_DONE && n < 400) begin
      cyc();
      n++;
      if (n == 99) c99 = cnt_clk;
      if (init_state == I_PRE && pre_at < 0) pre_at = n;
      if (init_state == I_AR) ars++;
      if (sdram_init_done && init_state != I_DONE) early = 1'b1;
      if (sdram_wr_ack || sdram_rd_ack) ack = 1'b1;
    end
    chk({tag, "_cnt_before_pre"}, c99, 99);
    chk({tag, "_pre_at"}, pre_at, 100);
    chk({tag, "_ar_pulses"}, ars, 8);
    chk({tag, "_total_cycles"}, n, 171);
    chk({tag, "_done_early"}, early, 0);
    chk({tag, "_ack_during_init"}, ack, 0);
    chk({tag, "_init_done"}, sdram_init_done, 1);
    chk({tag, "_work_idle"}, work_state, W_IDLE);
  endtask

  initial begin
    int n;
    int ar_seen;
    int acks;
    logic [3:0] prev;

    #1 rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_init_state", init_state, I_NOP);
    chk("rst_work_state", work_state, W_IDLE);
    chk("rst_cnt_clk", cnt_clk, 0);
    chk("rst_rd_wr", sdram_rd_wr, 1);
    chk("rst_acks", {sdram_wr_ack, sdram_rd_ack}, 0);
    chk("rst_init_done", sdram_init_done, 0);
    rst_n = 1'b1;

    run_init("init");

    // Write, burst 4; burst input changed after W_ACTIVE must be ignored.
    sdram_wr_req = 1'b1;
    sdram_wr_burst = 10'd4;
    add(W_ACTIVE, 1, 0, 0, 0); add(W_TRCD, 2, 0, 0, 0); add(W_WRITE, 1, 1, 0, 0);
    add(W_WD, 3, 1, 0, 0); add(W_TWR, 2, 0, 0, 0); add(W_PRE, 1, 0, 0, 0);
    add(W_TRP, 2, 0, 0, 0); add(W_IDLE, 1, 0, 0, 0);
    run_seq("wr4", 1'b1);

    // Read, burst 8: first ack 4 cycles after W_READ, 8 consecutive acks.
    sdram_rd_req = 1'b1;
    sdram_rd_burst = 10'd8;
    add(W_ACTIVE, 1, 0, 0, 1); add(W_TRCD, 2, 0, 0, 1); add(W_READ, 1, 0, 0, 1);
    add(W_CL, 2, 0, 0, 1); add(W_RD, 1, 0, 0, 1); add(W_RD, 7, 0, 1, 1);
    add(W_PRE, 1, 0, 1, 1); add(W_TRP, 2, 0, 0, 1); add(W_IDLE, 1, 0, 0, 1);
    run_seq("rd8", 1'b1);

    // Simultaneous requests: write 2, then read 3, then the refresh that
    // became pending during the read burst.
    sdram_wr_req = 1'b1; sdram_wr_burst = 10'd2;
    sdram_rd_req = 1'b1; sdram_rd_burst = 10'd3;
    add(W_ACTIVE, 1, 0, 0, 0); add(W_TRCD, 2, 0, 0, 0); add(W_WRITE, 1, 1, 0, 0);
    add(W_WD, 1, 1, 0, 0); add(W_TWR, 2, 0, 0, 0); add(W_PRE, 1, 0, 0, 0);
    add(W_TRP, 2, 0, 0, 0); add(W_IDLE, 1, 0, 0, 0);
    add(W_ACTIVE, 1, 0, 0, 1); add(W_TRCD, 2, 0, 0, 1); add(W_READ, 1, 0, 0, 1);
    add(W_CL, 2, 0, 0, 1); add(W_RD, 1, 0, 0, 1); add(W_RD, 2, 0, 1, 1);
    add(W_PRE, 1, 0, 1, 1); add(W_TRP, 2, 0, 0, 1); add(W_IDLE, 1, 0, 0, 1);
    add(W_AR, 1, 0, 0, 1); add(W_TRFC, 7, 0, 0, 1); add(W_IDLE, 1, 0, 0, 1);
    run_seq("wr_rd_ref", 1'b0);

    // Continuous 32-beat reads: refresh only from W_IDLE after each burst.
    sdram_rd_req = 1'b1;
    sdram_rd_burst = 10'd32;
    n = 0; ar_seen = 0; acks = 0; prev = work_state;
    for (int i = 0; i < 200 && ar_seen < 2; i++) begin
      cyc();
      n++;
      if (sdram_rd_ack) acks++;
      if (work_state == W_AR && prev != W_AR) begin
        ar_seen++;
        chk("ref_from_idle", prev, W_IDLE);
        chk("ref_entry_cycle", n, (ar_seen == 1) ? 43 : 94);
        chk("ref_acks_between", acks, 32);
        acks = 0;
      end
      prev = work_state;
    end
    chk("ref_count", ar_seen, 2);
    sdram_rd_req = 1'b0;
    for (int i = 0; i < 40 && work_state != W_IDLE; i++) cyc();
    chk("ref_back_idle", work_state, W_IDLE);

    // Reset in the middle of a write burst.
    sdram_wr_req = 1'b1;
    sdram_wr_burst = 10'd8;
    n = 0;
    for (int i = 0; i < 30 && work_state != W_WD; i++) begin
      cyc();
      n++;
      if (sdram_wr_ack) sdram_wr_req = 1'b0;
    end
    chk("wd_reached_cycle", n, 5);
    cyc(); cyc();
    chk("wd_ack_before_rst", {work_state, sdram_wr_ack}, {W_WD, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("midrst_init_state", init_state, I_NOP);
    chk("midrst_work_state", work_state, W_IDLE);
    chk("midrst_cnt_clk", cnt_clk, 0);
    chk("midrst_rd_wr", sdram_rd_wr, 1);
    chk("midrst_acks", {sdram_wr_ack, sdram_rd_ack}, 0);
    chk("midrst_init_done", sdram_init_done, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    run_init("reinit");

    // Burst length 0 behaves as a single beat.
    sdram_wr_req = 1'b1;
    sdram_wr_burst = 10'd0;
    add(W_ACTIVE, 1, 0, 0, 0); add(W_TRCD, 2, 0, 0, 0); add(W_WRITE, 1, 1, 0, 0);
    add(W_TWR, 2, 0, 0, 0); add(W_PRE, 1, 0, 0, 0); add(W_TRP, 2, 0, 0, 0);
    add(W_IDLE, 1, 0, 0, 0);
    run_seq("wr0", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
